// File: rtl/shift_sequencer.sv
// Multi-cycle ARM data-processing shifter operand sequencer with a register-file read handshake.
// Optional SHIFT_SEQ_FASTPATH_EN: immediate forms are computed in the START cycle and skip COMPUTE.
`default_nettype none

module shift_sequencer #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [DW-1:0] IR,
  input  logic          CIN,
  output logic          RF_REQ,
  output logic [AW-1:0] RF_ADDR,
  input  logic          RF_ACK,
  input  logic [DW-1:0] RF_DATA,
  output logic [DW-1:0] SHIFTER_OPERAND,
  output logic          COUT,
  output logic          DONE,
  input  logic          ACCEPT,
  output logic          BUSY
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_RS = 3'd1,
    FETCH_RM = 3'd2,
    COMPUTE  = 3'd3,
    HOLD     = 3'd4
  } state_t;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

`ifdef SHIFT_SEQ_FASTPATH_EN
  localparam state_t IMM_NEXT = HOLD;
`else
  localparam state_t IMM_NEXT = COMPUTE;
`endif

  state_t      state, next_state;
  logic [31:0] ir_lat;
  logic        cin_lat;
  logic [31:0] rm_val;
  logic [7:0]  rs_val;
  logic [31:0] operand;
  logic        carry;
  logic [32:0] result;
  logic        load_fast;
  logic [7:0]  amt_imm;
  logic        unused_ir;

  // Returns {carry, operand} for the 8-bit immediate rotated right by 2*rot.
  function automatic logic [32:0] imm_rot(input logic [11:0] imm12, input logic cin);
    logic [31:0] v;
    logic [4:0]  amt;
    logic [31:0] op;
    v   = {24'd0, imm12[7:0]};
    amt = {imm12[11:8], 1'b0};
    op  = (v >> amt) | (v << (5'd0 - amt));
    return {(imm12[11:8] == 4'd0) ? cin : op[31], op};
  endfunction

  // Shift with an 8-bit amount; bit indices are 5-bit so they never leave 0..31.
  function automatic logic [32:0] shift_core(input logic [1:0] typ, input logic [7:0] amt,
                                             input logic [31:0] rm, input logic cin);
    logic [4:0]  a5, am1, lsl_idx;
    logic [31:0] asr;
    logic [32:0] r;
    a5      = amt[4:0];
    am1     = a5 - 5'd1;
    lsl_idx = 5'd0 - a5;
    asr     = $signed(rm) >>> a5;
    r       = {cin, rm};
    if (amt != 8'd0) begin
      case (typ)
        T_LSL: begin
          if (amt < 8'd32)       r = {rm[lsl_idx], rm << a5};
          else if (amt == 8'd32) r = {rm[0], 32'd0};
          else                   r = 33'd0;
        end
        T_LSR: begin
          if (amt < 8'd32)       r = {rm[am1], rm >> a5};
          else if (amt == 8'd32) r = {rm[31], 32'd0};
          else                   r = 33'd0;
        end
        T_ASR: begin
          if (amt < 8'd32) r = {rm[am1], asr};
          else             r = {rm[31], {32{rm[31]}}};
        end
        default: begin
          if (a5 == 5'd0) r = {rm[31], rm};
          else            r = {rm[am1], (rm >> a5) | (rm << lsl_idx)};
        end
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    RF_REQ     = 1'b0;
    RF_ADDR    = '0;
    DONE       = 1'b0;
    BUSY       = 1'b1;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          if (IR[27:25] == 3'b001)   next_state = IMM_NEXT;
          else if (!IR[25] && IR[4]) next_state = FETCH_RS;
          else                       next_state = FETCH_RM;
        end
      end
      FETCH_RS: begin
        RF_REQ  = 1'b1;
        RF_ADDR = ir_lat[11:8];
        if (RF_ACK) next_state = FETCH_RM;
      end
      FETCH_RM: begin
        RF_REQ  = 1'b1;
        RF_ADDR = ir_lat[3:0];
        if (RF_ACK) next_state = COMPUTE;
      end
      COMPUTE: next_state = HOLD;
      HOLD: begin
        DONE = 1'b1;
        if (ACCEPT) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Immediate-shift amount of 0 encodes 32 for LSR/ASR; ROR #0 (RRX) is handled separately.
  always_comb begin
    amt_imm = {3'd0, ir_lat[11:7]};
    if (ir_lat[11:7] == 5'd0 && (ir_lat[6:5] == T_LSR || ir_lat[6:5] == T_ASR))
      amt_imm = 8'd32;
    if (ir_lat[27:25] == 3'b001)
      result = imm_rot(ir_lat[11:0], cin_lat);
    else if (!ir_lat[25] && ir_lat[4])
      result = shift_core(ir_lat[6:5], rs_val, rm_val, cin_lat);
    else if (ir_lat[6:5] == T_ROR && ir_lat[11:7] == 5'd0)
      result = {rm_val[0], cin_lat, rm_val[31:1]};
    else
      result = shift_core(ir_lat[6:5], amt_imm, rm_val, cin_lat);
  end

`ifdef SHIFT_SEQ_FASTPATH_EN
  assign load_fast = (state == IDLE) && START && (IR[27:25] == 3'b001);
`else
  assign load_fast = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir_lat  <= '0;
      cin_lat <= 1'b0;
      rm_val  <= '0;
      rs_val  <= '0;
      operand <= '0;
      carry   <= 1'b0;
    end else begin
      if (state == IDLE && START) begin
        ir_lat  <= IR;
        cin_lat <= CIN;
      end
      if (state == FETCH_RS && RF_ACK) rs_val <= RF_DATA[7:0];
      if (state == FETCH_RM && RF_ACK) rm_val <= RF_DATA;
      if (load_fast)
        {carry, operand} <= imm_rot(IR[11:0], CIN);
      else if (state == COMPUTE)
        {carry, operand} <= result;
    end
  end

  assign SHIFTER_OPERAND = operand;
  assign COUT            = carry;
  assign unused_ir       = ^{ir_lat[31:28], ir_lat[24:12]};

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors, handshake corner cases, random vs model.
`default_nettype none

module tb_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [31:0] IR = '0;
  logic        CIN = 1'b0;
  logic        RF_REQ;
  logic [3:0]  RF_ADDR;
  logic        RF_ACK = 1'b0;
  logic [31:0] RF_DATA = '0;
  logic [31:0] SHIFTER_OPERAND;
  logic        COUT;
  logic        DONE;
  logic        ACCEPT = 1'b0;
  logic        BUSY;

  int total = 0;
  int bad   = 0;
  logic [31:0] rf [16];

  shift_sequencer #(.DW(32), .AW(4)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .CIN(CIN),
    .RF_REQ(RF_REQ), .RF_ADDR(RF_ADDR), .RF_ACK(RF_ACK), .RF_DATA(RF_DATA),
    .SHIFTER_OPERAND(SHIFTER_OPERAND), .COUT(COUT), .DONE(DONE),
    .ACCEPT(ACCEPT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ir;
    logic        cin;
    logic [31:0] rs;
    logic [31:0] rm;
    logic [31:0] op;
    logic        c;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: {carry, operand} from the instruction rules, using wide shifts and bit loops.
  function automatic logic [32:0] model(input logic [31:0] ir, input logic cin,
                                        input logic [31:0] rs, input logic [31:0] rm);
    logic [31:0] v;
    logic        c;
    logic [71:0] tl;
    logic [32:0] tr;
    logic signed [64:0] ta;
    int amt, am, r;
    logic [1:0] typ;
    typ = ir[6:5];
    if (ir[27:25] == 3'b001) begin
      v = {24'd0, ir[7:0]};
      for (int i = 0; i < 2 * int'(ir[11:8]); i++) v = {v[0], v[31:1]};
      return {(ir[11:8] == 0) ? cin : v[31], v};
    end
    if (!ir[25] && ir[4]) amt = int'(rs[7:0]);
    else begin
      amt = int'(ir[11:7]);
      if (amt == 0 && typ == 2'b11) return {rm[0], cin, rm[31:1]};
      if (amt == 0 && (typ == 2'b01 || typ == 2'b10)) amt = 32;
    end
    if (amt == 0) return {cin, rm};
    am = (amt > 40) ? 40 : amt;
    case (typ)
      2'b00: begin tl = {40'd0, rm} << am; return {tl[32], tl[31:0]}; end
      2'b01: begin tr = {rm, 1'b0} >> am; return {tr[0], tr[32:1]}; end
      2'b10: begin
        ta = $signed({{32{rm[31]}}, rm, 1'b0}) >>> ((am > 32) ? 32 : am);
        return {ta[0], ta[32:1]};
      end
      default: begin
        r = amt % 32;
        if (r == 0) return {rm[31], rm};
        v = rm; c = 1'b0;
        for (int i = 0; i < r; i++) begin c = v[0]; v = {v[0], v[31:1]}; end
        return {c, v};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] ir, input int w);
    if (ir[27:25] == 3'b001) begin
`ifdef SHIFT_SEQ_FASTPATH_EN
      return 1;
`else
      return 2;
`endif
    end
    if (!ir[25] && ir[4]) return 4 + 2 * w;
    return 3 + w;
  endfunction

  // Runs one operation with an RF responder, then checks result, latency, fetch order and stability.
  task automatic exec_check(input string tag, input logic [31:0] ir, input logic cin,
                            input int ack_wait, input int acc_wait, input bit pulse_busy,
                            input logic [31:0] exp_op, input logic exp_c);
    int wcnt = 0, naddr = 0, lat = 0, exp_n;
    bit pending = 0, stable_ok = 1, hold_ok = 1, timeout = 1;
    logic [3:0] paddr = '0, a0 = '0, a1 = '0;
    logic [31:0] op;
    logic c;
    @(negedge CLK);
    START = 1'b1; IR = ir; CIN = cin;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge CLK);
      START  = 1'b0;
      RF_ACK = 1'b0;
      if (DONE) begin lat = cyc; timeout = 0; break; end
      if (pulse_busy && cyc == 1) begin START = 1'b1; IR = $urandom; CIN = ~cin; end
      if (RF_REQ) begin
        if (pending && RF_ADDR != paddr) stable_ok = 0;
        if (wcnt == ack_wait) begin
          RF_ACK  = 1'b1;
          RF_DATA = rf[RF_ADDR];
          if (naddr == 0) a0 = RF_ADDR; else a1 = RF_ADDR;
          naddr++; wcnt = 0; pending = 0;
        end else begin
          wcnt++; pending = 1; paddr = RF_ADDR; RF_DATA = $urandom;
        end
      end else begin
        RF_ACK  = 1'($urandom % 2);
        RF_DATA = $urandom;
      end
    end
    RF_ACK = 1'b0;
    chk({tag, " timeout"}, 64'(timeout), 64'd0);
    op = SHIFTER_OPERAND; c = COUT;
    for (int k = 0; k < acc_wait; k++) begin
      @(negedge CLK);
      if (!DONE || !BUSY || SHIFTER_OPERAND !== op || COUT !== c) hold_ok = 0;
    end
    ACCEPT = 1'b1;
    @(negedge CLK);
    ACCEPT = 1'b0;
    if (DONE || BUSY) hold_ok = 0;
    chk({tag, " operand"}, 64'(op), 64'(exp_op));
    chk({tag, " cout"}, 64'(c), 64'(exp_c));
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(ir, ack_wait)));
    exp_n = (ir[27:25] == 3'b001) ? 0 : ((!ir[25] && ir[4]) ? 2 : 1);
    chk({tag, " nfetch"}, 64'(naddr), 64'(exp_n));
    if (exp_n == 2) begin
      chk({tag, " addr0"}, 64'(a0), 64'(ir[11:8]));
      chk({tag, " addr1"}, 64'(a1), 64'(ir[3:0]));
    end else if (exp_n == 1) chk({tag, " addr0"}, 64'(a0), 64'(ir[3:0]));
    chk({tag, " req_stable"}, 64'(stable_ok), 64'd1);
    chk({tag, " hold"}, 64'(hold_ok), 64'd1);
  endtask

  task automatic load_rf(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rm);
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[ir[11:8]] = rs;
    rf[ir[3:0]]  = rm;
  endtask

  initial begin
    vec_t tv [7];
    logic [31:0] ir, rs, rm;
    logic cin;
    logic [32:0] m;

    tv[0] = '{32'h02A003FF, 1'b0, 32'h0,        32'h0,        32'hFC000003, 1'b1};
    tv[1] = '{32'hE1A00021, 1'b0, 32'h0,        32'h80000001, 32'h00000000, 1'b1};
    tv[2] = '{32'hE1A00061, 1'b1, 32'h0,        32'h80000001, 32'hC0000000, 1'b1};
    tv[3] = '{32'hE1A00211, 1'b0, 32'd32,       32'h00000001, 32'h00000000, 1'b1};
    tv[4] = '{32'hE1A00211, 1'b0, 32'd33,       32'h00000001, 32'h00000000, 1'b0};
    tv[5] = '{32'hE1A00271, 1'b0, 32'h40,       32'h80000000, 32'h80000000, 1'b1};
    tv[6] = '{32'hE1A00251, 1'b0, 32'hFF,       32'h80000000, 32'hFFFFFFFF, 1'b1};

    #12;
    chk("reset_outputs", 64'({SHIFTER_OPERAND, COUT, DONE, RF_REQ, RF_ADDR, BUSY}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_rf(tv[i].ir, tv[i].rs, tv[i].rm);
      exec_check($sformatf("vec%0d", i), tv[i].ir, tv[i].cin, 0, 0, 0, tv[i].op, tv[i].c);
    end

    // RF_ACK withheld 5 cycles per fetch
    load_rf(tv[3].ir, tv[3].rs, tv[3].rm);
    exec_check("ackwait", tv[3].ir, 1'b0, 5, 0, 0, tv[3].op, tv[3].c);
    // ACCEPT withheld 3 cycles plus a START pulse while busy
    load_rf(tv[6].ir, tv[6].rs, tv[6].rm);
    exec_check("accwait", tv[6].ir, 1'b0, 0, 3, 1, tv[6].op, tv[6].c);
    load_rf(tv[0].ir, 0, 0);
    exec_check("imm_busy", tv[0].ir, 1'b0, 0, 2, 1, tv[0].op, tv[0].c);

    // Asynchronous reset while stalled in FETCH_RM
    load_rf(tv[1].ir, tv[1].rs, tv[1].rm);
    @(negedge CLK);
    START = 1'b1; IR = tv[1].ir; CIN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("pre_reset_req", 64'({RF_REQ, BUSY}), 64'b11);
    #2 RESET = 1'b1;
    #1 chk("async_reset", 64'({RF_REQ, BUSY, DONE}), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    exec_check("after_reset", tv[1].ir, tv[1].cin, 0, 0, 0, tv[1].op, tv[1].c);

    for (int n = 0; n < 80; n++) begin
      ir = $urandom;
      cin = 1'($urandom % 2);
      case ($urandom % 4)
        0: ir[27:25] = 3'b001;
        1: begin ir[25] = 1'b0; ir[4] = 1'b1; end
        2: begin ir[25] = 1'b0; ir[4] = 1'b0; end
        default: ir[27:25] = 3'b101;
      endcase
      rs = ($urandom % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rm = $urandom;
      load_rf(ir, rs, rm);
      m = model(ir, cin, rf[ir[11:8]], rf[ir[3:0]]);
      exec_check($sformatf("rnd%0d", n), ir, cin, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom % 2), m[31:0], m[32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
